// File: rtl/memory_port_arbiter_if.sv
// Bundle of the two requester ports, the memory-side ports and the conflict counter
// connecting the arbiter (slave side) to requesters and memory (master side).
interface memory_port_arbiter_if;
  logic        r0_req_valid;
  logic        r0_req_ready;
  logic        r0_req_write;
  logic [31:0] r0_req_addr;
  logic [31:0] r0_req_wdata;
  logic        r0_resp_valid;
  logic [31:0] r0_resp_rdata;
  logic        r0_resp_err;

  logic        r1_req_valid;
  logic        r1_req_ready;
  logic        r1_req_write;
  logic [31:0] r1_req_addr;
  logic [31:0] r1_req_wdata;
  logic        r1_resp_valid;
  logic [31:0] r1_resp_rdata;
  logic        r1_resp_err;

  logic [31:0] mem_read_address_0;
  logic [31:0] mem_read_address_1;
  logic [31:0] mem_read_data_0;
  logic [31:0] mem_read_data_1;
  logic [31:0] mem_write_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;

  logic [15:0] conflict_count;

  modport slave (
    input  r0_req_valid, r0_req_write, r0_req_addr, r0_req_wdata,
    output r0_req_ready, r0_resp_valid, r0_resp_rdata, r0_resp_err,
    input  r1_req_valid, r1_req_write, r1_req_addr, r1_req_wdata,
    output r1_req_ready, r1_resp_valid, r1_resp_rdata, r1_resp_err,
    output mem_read_address_0, mem_read_address_1,
    input  mem_read_data_0, mem_read_data_1,
    output mem_write_address, mem_write_data, mem_write_enable,
    output conflict_count
  );

  modport master (
    output r0_req_valid, r0_req_write, r0_req_addr, r0_req_wdata,
    input  r0_req_ready, r0_resp_valid, r0_resp_rdata, r0_resp_err,
    output r1_req_valid, r1_req_write, r1_req_addr, r1_req_wdata,
    input  r1_req_ready, r1_resp_valid, r1_resp_rdata, r1_resp_err,
    input  mem_read_address_0, mem_read_address_1,
    output mem_read_data_0, mem_read_data_1,
    input  mem_write_address, mem_write_data, mem_write_enable,
    input  conflict_count
  );
endinterface

// File: rtl/memory_port_arbiter.sv
// Two-requester front end for a dual-read / single-write memory: reads go straight to
// their own port, writes share one port under round-robin arbitration, 1-cycle responses.
module memory_port_arbiter #(
  parameter int DEPTH = 2048
) (
  input logic                  clk,
  input logic                  rst_n,
  memory_port_arbiter_if.slave bus
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  function automatic logic addr_oor(input logic [31:0] a);
    return a >= DEPTH_U;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  function automatic logic [31:0] resp_data(input logic acc, input logic rd,
                                            input logic oor, input logic [31:0] d);
    return (acc & rd & ~oor) ? d : 32'd0;
  endfunction

  logic        rd0, rd1, wr0, wr1;
  logic        gnt0, gnt1;
  logic        acc0, acc1;
  logic        oor0, oor1;
  logic [31:0] gnt_addr, gnt_wdata;
  logic        gnt_any;

  logic        prio_p1;
  logic [15:0] conflict_p1;
  logic        r0_vld_p1, r1_vld_p1;
  logic        r0_err_p1, r1_err_p1;
  logic [31:0] r0_rdata_p1, r1_rdata_p1;

  assign rd0  = bus.r0_req_valid & ~bus.r0_req_write;
  assign rd1  = bus.r1_req_valid & ~bus.r1_req_write;
  assign wr0  = bus.r0_req_valid &  bus.r0_req_write;
  assign wr1  = bus.r1_req_valid &  bus.r1_req_write;
  assign oor0 = addr_oor(bus.r0_req_addr);
  assign oor1 = addr_oor(bus.r1_req_addr);

  // prio names the requester that wins when both write in the same cycle
  assign gnt0 = rst_n & wr0 & (~wr1 | ~prio_p1);
  assign gnt1 = rst_n & wr1 & (~wr0 |  prio_p1);

  assign bus.r0_req_ready = rst_n & (rd0 | gnt0);
  assign bus.r1_req_ready = rst_n & (rd1 | gnt1);
  assign acc0 = bus.r0_req_valid & bus.r0_req_ready;
  assign acc1 = bus.r1_req_valid & bus.r1_req_ready;

  assign bus.mem_read_address_0 = bus.r0_req_addr;
  assign bus.mem_read_address_1 = bus.r1_req_addr;

  always_comb begin
    gnt_addr  = gnt1 ? bus.r1_req_addr  : bus.r0_req_addr;
    gnt_wdata = gnt1 ? bus.r1_req_wdata : bus.r0_req_wdata;
    gnt_any   = gnt0 | gnt1;
    bus.mem_write_enable  = gnt_any & ~addr_oor(gnt_addr);
    bus.mem_write_address = bus.mem_write_enable ? gnt_addr  : 32'd0;
    bus.mem_write_data    = bus.mem_write_enable ? gnt_wdata : 32'd0;
  end

  // Stage p1: arbitration state and the registered response of each accepted request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_p1     <= 1'b0;
      conflict_p1 <= 16'd0;
      r0_vld_p1   <= 1'b0;
      r1_vld_p1   <= 1'b0;
      r0_err_p1   <= 1'b0;
      r1_err_p1   <= 1'b0;
      r0_rdata_p1 <= 32'd0;
      r1_rdata_p1 <= 32'd0;
    end else begin
      if (gnt0)
        prio_p1 <= 1'b1;
      else if (gnt1)
        prio_p1 <= 1'b0;
      if (wr0 & wr1)
        conflict_p1 <= sat_inc16(conflict_p1);
      r0_vld_p1   <= acc0;
      r1_vld_p1   <= acc1;
      r0_err_p1   <= acc0 & oor0;
      r1_err_p1   <= acc1 & oor1;
      r0_rdata_p1 <= resp_data(acc0, rd0, oor0, bus.mem_read_data_0);
      r1_rdata_p1 <= resp_data(acc1, rd1, oor1, bus.mem_read_data_1);
    end
  end

  assign bus.r0_resp_valid  = r0_vld_p1;
  assign bus.r1_resp_valid  = r1_vld_p1;
  assign bus.r0_resp_err    = r0_err_p1;
  assign bus.r1_resp_err    = r1_err_p1;
  assign bus.r0_resp_rdata  = r0_rdata_p1;
  assign bus.r1_resp_rdata  = r1_rdata_p1;
  assign bus.conflict_count = conflict_p1;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: per-cycle vector table for grants/write port, a reference
// memory feeding a response scoreboard, and a long contention run for counter saturation.
module tb_memory_port_arbiter;

  localparam int DEPTH = 2048;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  memory_port_arbiter_if bus();

  memory_port_arbiter #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Attached memory: combinational read ports, write committed on the clock edge
  logic [31:0] mem [0:DEPTH-1];
  assign bus.mem_read_data_0 = (bus.mem_read_address_0 < 32'(DEPTH)) ?
                               mem[bus.mem_read_address_0[10:0]] : 32'hBADBAD00;
  assign bus.mem_read_data_1 = (bus.mem_read_address_1 < 32'(DEPTH)) ?
                               mem[bus.mem_read_address_1[10:0]] : 32'hBADBAD01;
  always @(posedge clk)
    if (bus.mem_write_enable && bus.mem_write_address < 32'(DEPTH))
      mem[bus.mem_write_address[10:0]] <= bus.mem_write_data;

  typedef struct {
    logic        rst_n;
    logic        v0, w0;
    logic [31:0] a0, d0;
    logic        v1, w1;
    logic [31:0] a1, d1;
    logic        e_rdy0, e_rdy1, e_we;
  } vec_t;

  typedef struct {
    logic        v;
    logic        err;
    logic [31:0] d;
  } resp_t;

  vec_t        vecs[$];
  resp_t       q0[$], q1[$];
  logic [31:0] ref_mem [0:DEPTH-1];
  logic [15:0] ref_conflict;
  int          errors = 0;
  int          checks = 0;

  function automatic vec_t mk(logic r, logic v0, logic w0, logic [31:0] a0, logic [31:0] d0,
                              logic v1, logic w1, logic [31:0] a1, logic [31:0] d1,
                              logic e0, logic e1, logic ewe);
    vec_t t;
    t.rst_n = r; t.v0 = v0; t.w0 = w0; t.a0 = a0; t.d0 = d0;
    t.v1 = v1; t.w1 = w1; t.a1 = a1; t.d1 = d1;
    t.e_rdy0 = e0; t.e_rdy1 = e1; t.e_we = ewe;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_resp();
    resp_t e0, e1;
    e0 = '{v: 1'b0, err: 1'b0, d: 32'd0};
    e1 = e0;
    if (q0.size() > 0) e0 = q0.pop_front();
    if (q1.size() > 0) e1 = q1.pop_front();
    chk("r0_resp_valid", 32'(bus.r0_resp_valid), 32'(e0.v));
    chk("r0_resp_err",   32'(bus.r0_resp_err),   32'(e0.err));
    chk("r0_resp_rdata", bus.r0_resp_rdata,      e0.d);
    chk("r1_resp_valid", 32'(bus.r1_resp_valid), 32'(e1.v));
    chk("r1_resp_err",   32'(bus.r1_resp_err),   32'(e1.err));
    chk("r1_resp_rdata", bus.r1_resp_rdata,      e1.d);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] e_wa, e_wd;
    resp_t       p0, p1;
    logic        acc0, acc1;
    rst_n            = v.rst_n;
    bus.r0_req_valid = v.v0; bus.r0_req_write = v.w0;
    bus.r0_req_addr  = v.a0; bus.r0_req_wdata = v.d0;
    bus.r1_req_valid = v.v1; bus.r1_req_write = v.w1;
    bus.r1_req_addr  = v.a1; bus.r1_req_wdata = v.d1;
    e_wa = 32'd0;
    e_wd = 32'd0;
    if (v.e_we) begin
      e_wa = (v.e_rdy0 && v.w0) ? v.a0 : v.a1;
      e_wd = (v.e_rdy0 && v.w0) ? v.d0 : v.d1;
    end
    @(negedge clk);
    chk($sformatf("v%0d r0_req_ready", idx), 32'(bus.r0_req_ready), 32'(v.e_rdy0));
    chk($sformatf("v%0d r1_req_ready", idx), 32'(bus.r1_req_ready), 32'(v.e_rdy1));
    chk($sformatf("v%0d mem_write_enable", idx), 32'(bus.mem_write_enable), 32'(v.e_we));
    chk($sformatf("v%0d mem_write_address", idx), bus.mem_write_address, e_wa);
    chk($sformatf("v%0d mem_write_data", idx), bus.mem_write_data, e_wd);
    chk($sformatf("v%0d mem_read_address_0", idx), bus.mem_read_address_0, v.a0);
    chk($sformatf("v%0d mem_read_address_1", idx), bus.mem_read_address_1, v.a1);
    chk($sformatf("v%0d conflict_count", idx), 32'(bus.conflict_count), 32'(ref_conflict));
    check_resp();
    @(posedge clk);
    acc0 = v.rst_n && v.v0 && v.e_rdy0;
    acc1 = v.rst_n && v.v1 && v.e_rdy1;
    p0.v   = acc0;
    p0.err = acc0 && (v.a0 >= 32'(DEPTH));
    p0.d   = (acc0 && !v.w0 && !p0.err) ? ref_mem[v.a0[10:0]] : 32'd0;
    p1.v   = acc1;
    p1.err = acc1 && (v.a1 >= 32'(DEPTH));
    p1.d   = (acc1 && !v.w1 && !p1.err) ? ref_mem[v.a1[10:0]] : 32'd0;
    q0.push_back(p0);
    q1.push_back(p1);
    if (v.rst_n && v.e_we) ref_mem[e_wa[10:0]] = e_wd;
    if (!v.rst_n) ref_conflict = 16'd0;
    else if (v.v0 && v.w0 && v.v1 && v.w1 && ref_conflict != 16'hFFFF) ref_conflict++;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.r0_req_valid = 1'b0; bus.r0_req_write = 1'b0;
    bus.r0_req_addr  = 32'd0; bus.r0_req_wdata = 32'd0;
    bus.r1_req_valid = 1'b0; bus.r1_req_write = 1'b0;
    bus.r1_req_addr  = 32'd0; bus.r1_req_wdata = 32'd0;
    ref_conflict = 16'd0;

    //            rst v0 w0 a0           d0            v1 w1 a1     d1     rdy0 rdy1 we
    vecs.push_back(mk(0, 1, 1, 32'd3,        32'h1,        1, 0, 32'd4, 32'h0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 32'd5,        32'hDEADBEEF, 0, 0, 32'd0, 32'h0, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 32'd5,        32'h0,        0, 0, 32'd0, 32'h0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 32'd0,        32'h0,        0, 0, 32'd0, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'd0,        32'h0,        0, 0, 32'd0, 32'h0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 32'd1,        32'h11,       1, 1, 32'd2, 32'h22, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 32'd0,        32'h0,        1, 1, 32'd2, 32'h22, 0, 1, 1));
    vecs.push_back(mk(1, 1, 0, 32'd1,        32'h0,        1, 0, 32'd2, 32'h0, 1, 1, 0));
    vecs.push_back(mk(1, 1, 1, 32'd10,       32'hA0,       1, 1, 32'd20, 32'hB0, 1, 0, 1));
    vecs.push_back(mk(1, 1, 1, 32'd11,       32'hA1,       1, 1, 32'd20, 32'hB0, 0, 1, 1));
    vecs.push_back(mk(1, 1, 1, 32'd11,       32'hA1,       1, 1, 32'd21, 32'hB1, 1, 0, 1));
    vecs.push_back(mk(1, 1, 1, 32'd12,       32'hA2,       1, 1, 32'd21, 32'hB1, 0, 1, 1));
    vecs.push_back(mk(1, 1, 1, 32'd12,       32'hA2,       1, 1, 32'd22, 32'hB2, 1, 0, 1));
    vecs.push_back(mk(1, 1, 1, 32'd13,       32'hA3,       1, 1, 32'd22, 32'hB2, 0, 1, 1));
    vecs.push_back(mk(1, 1, 1, 32'd13,       32'hA3,       1, 0, 32'd22, 32'h0, 1, 1, 1));
    vecs.push_back(mk(1, 1, 0, 32'd13,       32'h0,        1, 0, 32'd20, 32'h0, 1, 1, 0));
    vecs.push_back(mk(1, 1, 1, 32'd9,        32'h5,        0, 0, 32'd0, 32'h0, 1, 0, 1));
    vecs.push_back(mk(1, 1, 1, 32'd9,        32'h7,        1, 0, 32'd9, 32'h0, 1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 32'd0,        32'h0,        1, 0, 32'd9, 32'h0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 32'd0,        32'h0,        1, 1, 32'd2048, 32'h99, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 32'hFFFFFFFF, 32'h0,        0, 0, 32'd0, 32'h0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 32'd4096,     32'h44,       1, 1, 32'd30, 32'h30, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 32'd0,        32'h0,        1, 1, 32'd30, 32'h30, 0, 1, 1));
    vecs.push_back(mk(1, 1, 0, 32'd5,        32'h0,        1, 0, 32'd30, 32'h0, 1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 32'd1,        32'h0,        1, 0, 32'd2, 32'h0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 32'd5,        32'h0,        1, 0, 32'd9, 32'h0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 32'd10,       32'h0,        0, 0, 32'd0, 32'h0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 32'd14,       32'hC0,       1, 1, 32'd15, 32'hC1, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 32'd0,        32'h0,        1, 1, 32'd15, 32'hC1, 0, 1, 1));
    vecs.push_back(mk(1, 1, 0, 32'd14,       32'h0,        1, 0, 32'd15, 32'h0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 1, 32'd3,        32'h3,        0, 1, 32'd6, 32'h6, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 32'd0,        32'h0,        0, 0, 32'd0, 32'h0, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);
    @(negedge clk);
    check_resp();

    // Counter saturation under continuous two-way write contention
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.r0_req_valid = 1'b1; bus.r0_req_write = 1'b1;
    bus.r0_req_addr  = 32'd100; bus.r0_req_wdata = 32'h100;
    bus.r1_req_valid = 1'b1; bus.r1_req_write = 1'b1;
    bus.r1_req_addr  = 32'd101; bus.r1_req_wdata = 32'h101;
    chk("sat conflict_count after reset", 32'(bus.conflict_count), 32'd0);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat conflict_count 65534", 32'(bus.conflict_count), 32'h0000FFFE);
    @(posedge clk);
    #1;
    chk("sat conflict_count 65535", 32'(bus.conflict_count), 32'h0000FFFF);
    repeat (4) @(posedge clk);
    #1;
    chk("sat conflict_count held", 32'(bus.conflict_count), 32'h0000FFFF);
    chk("sat write port busy", 32'(bus.mem_write_enable), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
